// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter that shares one SPI master among NUM_REQ requesters, one transaction per grant.
// Optional RUN watchdog: define SPI_ARB_TIMEOUT_EN to abort a RUN that lasts TIMEOUT cycles.
module spi_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     req_wr,
  input  logic [8*NUM_REQ-1:0]   req_addr,
  input  logic [8*NUM_REQ-1:0]   req_din,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     ack,
  output logic [7:0]             rsp_dout,
  output logic                   rsp_err,
  output logic                   busy,
  output logic                   m_rst,
  output logic                   m_wr,
  output logic [7:0]             m_addr,
  output logic [7:0]             m_din,
  input  logic                   m_done,
  input  logic                   m_err,
  input  logic [7:0]             m_dout
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_r;
  logic [IW-1:0]   ptr_r;
  logic [IW-1:0]   win_r;
  logic [IW-1:0]   win_s;
  logic            found_s;
  logic [IW-1:0]   ptr_next_s;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CW-1:0] cnt_r;
`else
  logic unused_timeout_s;
  assign unused_timeout_s = ^TIMEOUT;
`endif

  // Round-robin search: first requester at or after ptr_r, wrapping modulo NUM_REQ.
  always_comb begin
    int   idx_v;
    logic take_v;
    found_s = 1'b0;
    win_s   = '0;
    idx_v   = 0;
    take_v  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_v   = (int'(ptr_r) + i) % NUM_REQ;
      take_v  = !found_s && req[IW'(idx_v)];
      win_s   = take_v ? IW'(idx_v) : win_s;
      found_s = found_s | take_v;
    end
  end

  assign ptr_next_s = (win_r == IW'(NUM_REQ - 1)) ? '0 : win_r + IW'(1);

  // Sequencer: grant, run one master transaction, return the response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      ptr_r    <= '0;
      win_r    <= '0;
      gnt      <= '0;
      ack      <= '0;
      busy     <= 1'b0;
      rsp_dout <= 8'h00;
      rsp_err  <= 1'b0;
      m_rst    <= 1'b1;
      m_wr     <= 1'b0;
      m_addr   <= 8'h00;
      m_din    <= 8'h00;
`ifdef SPI_ARB_TIMEOUT_EN
      cnt_r    <= '0;
`endif
    end else begin
      gnt <= '0;
      ack <= '0;
      case (state_r)
        IDLE: begin
          if (found_s) begin
            win_r   <= win_s;
            gnt     <= onehot(win_s);
            m_wr    <= req_wr[win_s];
            m_addr  <= req_addr[{win_s, 3'b000} +: 8];
            m_din   <= req_din[{win_s, 3'b000} +: 8];
            busy    <= 1'b1;
            m_rst   <= 1'b0;
            state_r <= RUN;
`ifdef SPI_ARB_TIMEOUT_EN
            cnt_r   <= '0;
`endif
          end else begin
            m_rst   <= 1'b1;
            state_r <= IDLE;
          end
        end
        RUN: begin
          if (m_done) begin
            rsp_dout <= m_dout;
            rsp_err  <= m_err;
            ack      <= onehot(win_r);
            m_rst    <= 1'b1;
            state_r  <= RESP;
`ifdef SPI_ARB_TIMEOUT_EN
          end else if (cnt_r == CW'(TIMEOUT - 1)) begin
            // Watchdog expiry reports as an error with no data.
            rsp_dout <= 8'h00;
            rsp_err  <= 1'b1;
            ack      <= onehot(win_r);
            m_rst    <= 1'b1;
            state_r  <= RESP;
          end else begin
            cnt_r    <= cnt_r + CW'(1);
            state_r  <= RUN;
          end
`else
          end else begin
            state_r  <= RUN;
          end
`endif
        end
        RESP: begin
          busy    <= 1'b0;
          m_rst   <= 1'b1;
          ptr_r   <= ptr_next_s;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          m_rst   <= 1'b1;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed self-checking bench for spi_req_arbiter (NUM_REQ=4, TIMEOUT=20).
module tb_spi_req_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [3:0]  req_wr = 4'b0000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_din = 32'h0;
  logic [3:0]  gnt, ack;
  logic [7:0]  rsp_dout;
  logic        rsp_err, busy, m_rst, m_wr;
  logic [7:0]  m_addr, m_din;
  logic        m_done = 1'b0;
  logic        m_err = 1'b0;
  logic [7:0]  m_dout = 8'h00;

  int checks = 0;
  int failures = 0;

  spi_req_arbiter #(.NUM_REQ(4), .TIMEOUT(20)) dut (
    .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_addr(req_addr), .req_din(req_din),
    .gnt(gnt), .ack(ack), .rsp_dout(rsp_dout), .rsp_err(rsp_err), .busy(busy),
    .m_rst(m_rst), .m_wr(m_wr), .m_addr(m_addr), .m_din(m_din),
    .m_done(m_done), .m_err(m_err), .m_dout(m_dout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL rst_gnt got=%b exp=0000", gnt); end
    checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL rst_ack got=%b exp=0000", ack); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (m_rst !== 1'b1) begin failures++; $display("FAIL rst_m_rst got=%b exp=1", m_rst); end
    checks++; if ({m_wr, m_addr, m_din} !== 17'h0) begin failures++; $display("FAIL rst_m_fields got=%h exp=0", {m_wr, m_addr, m_din}); end
    checks++; if ({rsp_err, rsp_dout} !== 9'h0) begin failures++; $display("FAIL rst_rsp got=%h exp=0", {rsp_err, rsp_dout}); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    req = 4'b0001; req_wr = 4'b0001; req_addr[7:0] = 8'h05; req_din[7:0] = 8'hA5;
    tick();
    req = 4'b0000;
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL wr_gnt got=%b exp=0001", gnt); end
    checks++; if (busy !== 1'b1 || m_rst !== 1'b0) begin failures++; $display("FAIL wr_run_flags got=busy%b/mrst%b exp=busy1/mrst0", busy, m_rst); end
    checks++; if ({m_wr, m_addr, m_din} !== {1'b1, 8'h05, 8'hA5}) begin failures++; $display("FAIL wr_fields got=%h exp=%h", {m_wr, m_addr, m_din}, {1'b1, 8'h05, 8'hA5}); end
    tick();
    tick();
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL wr_gnt_pulse got=%b exp=0000", gnt); end
    checks++; if ({m_rst, m_wr, m_addr, m_din} !== {1'b0, 1'b1, 8'h05, 8'hA5}) begin failures++; $display("FAIL wr_hold got=%h exp=%h", {m_rst, m_wr, m_addr, m_din}, {1'b0, 1'b1, 8'h05, 8'hA5}); end
    m_done = 1'b1; m_dout = 8'h00; m_err = 1'b0;
    tick();
    m_done = 1'b0;
    checks++; if (ack !== 4'b0001) begin failures++; $display("FAIL wr_ack got=%b exp=0001", ack); end
    checks++; if ({m_rst, busy, rsp_err} !== 3'b110) begin failures++; $display("FAIL wr_resp_flags got=%b exp=110", {m_rst, busy, rsp_err}); end
    tick();
    checks++; if ({ack, busy} !== 5'b0) begin failures++; $display("FAIL wr_after_ack got=%b exp=00000", {ack, busy}); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_v;
    do_reset();
    req = 4'b1111; req_wr = 4'b0000;
    for (int n = 0; n < 5; n++) begin
      exp_v = 4'b0001 << (n % 4);
      tick();
      checks++; if (gnt !== exp_v) begin failures++; $display("FAIL rr_gnt%0d got=%b exp=%b", n, gnt, exp_v); end
      tick();
      m_done = 1'b1;
      tick();
      m_done = 1'b0;
      checks++; if (ack !== exp_v) begin failures++; $display("FAIL rr_ack%0d got=%b exp=%b", n, ack, exp_v); end
      tick();
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_read();
    req = 4'b0100; req_wr = 4'b0000; req_addr[23:16] = 8'h10;
    tick();
    req = 4'b0000;
    checks++; if ({gnt, m_wr, m_addr} !== {4'b0100, 1'b0, 8'h10}) begin failures++; $display("FAIL rd_gnt got=%h exp=%h", {gnt, m_wr, m_addr}, {4'b0100, 1'b0, 8'h10}); end
    tick();
    m_done = 1'b1; m_dout = 8'h3C; m_err = 1'b0;
    tick();
    m_done = 1'b0; m_dout = 8'hFF;
    checks++; if (ack !== 4'b0100) begin failures++; $display("FAIL rd_ack got=%b exp=0100", ack); end
    checks++; if ({rsp_err, rsp_dout} !== {1'b0, 8'h3C}) begin failures++; $display("FAIL rd_rsp got=%h exp=%h", {rsp_err, rsp_dout}, {1'b0, 8'h3C}); end
    tick();
    tick();
    checks++; if (rsp_dout !== 8'h3C) begin failures++; $display("FAIL rd_hold got=%h exp=3c", rsp_dout); end
  endtask

  task automatic test_error();
    req = 4'b0010; req_wr = 4'b0010; req_addr[15:8] = 8'h40; req_din[15:8] = 8'h5A;
    tick();
    req = 4'b0000;
    checks++; if ({gnt, m_addr, m_din} !== {4'b0010, 8'h40, 8'h5A}) begin failures++; $display("FAIL err_gnt got=%h exp=%h", {gnt, m_addr, m_din}, {4'b0010, 8'h40, 8'h5A}); end
    tick();
    checks++; if (rsp_dout !== 8'h3C) begin failures++; $display("FAIL err_prev_hold got=%h exp=3c", rsp_dout); end
    m_done = 1'b1; m_err = 1'b1; m_dout = 8'h99;
    tick();
    m_done = 1'b0; m_err = 1'b0;
    checks++; if ({ack, rsp_err, rsp_dout} !== {4'b0010, 1'b1, 8'h99}) begin failures++; $display("FAIL err_ack got=%h exp=%h", {ack, rsp_err, rsp_dout}, {4'b0010, 1'b1, 8'h99}); end
    tick();
    checks++; if ({busy, ack} !== 5'b0) begin failures++; $display("FAIL err_busy_low got=%b exp=00000", {busy, ack}); end
  endtask

  task automatic test_pointer_skip();
    // ptr is 2 after serving requester 1: 1011 must go to 3, then wrap to 0.
    req = 4'b1011; req_wr = 4'b0000;
    tick();
    checks++; if (gnt !== 4'b1000) begin failures++; $display("FAIL skip_gnt got=%b exp=1000", gnt); end
    m_done = 1'b1;
    tick();
    m_done = 1'b0;
    checks++; if (ack !== 4'b1000) begin failures++; $display("FAIL skip_ack got=%b exp=1000", ack); end
    tick();
    tick();
    req = 4'b0000;
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL skip_wrap got=%b exp=0001", gnt); end
    m_done = 1'b1;
    tick();
    m_done = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_run();
    req = 4'b0100; req_addr[23:16] = 8'h77;
    tick();
    req = 4'b0000;
    checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL mid_gnt got=%b exp=0100", gnt); end
    tick();
    #2 rst = 1'b0;
    #1;
    checks++; if ({m_rst, busy, gnt, ack} !== 10'b10_0000_0000) begin failures++; $display("FAIL mid_async got=%b exp=1000000000", {m_rst, busy, gnt, ack}); end
    checks++; if (m_addr !== 8'h00) begin failures++; $display("FAIL mid_addr got=%h exp=00", m_addr); end
    tick();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL mid_no_ack got=%b exp=0000", ack); end
    req = 4'b1001;
    tick();
    req = 4'b0000;
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL mid_fresh_gnt got=%b exp=0001", gnt); end
    m_done = 1'b1;
    tick();
    m_done = 1'b0;
    tick();
  endtask

`ifdef SPI_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int seen_v;
    seen_v = 0;
    req = 4'b0001; m_dout = 8'hEE;
    tick();
    req = 4'b0000;
    for (int n = 1; n <= 40 && seen_v == 0; n++) begin
      tick();
      if (ack !== 4'b0000) seen_v = n;
    end
    checks++; if (seen_v != 20) begin failures++; $display("FAIL to_cycles got=%0d exp=20", seen_v); end
    checks++; if ({ack, rsp_err, rsp_dout, m_rst} !== {4'b0001, 1'b1, 8'h00, 1'b1}) begin failures++; $display("FAIL to_rsp got=%h exp=%h", {ack, rsp_err, rsp_dout, m_rst}, {4'b0001, 1'b1, 8'h00, 1'b1}); end
    tick();
  endtask
`else
  task automatic test_timeout();
    int seen_v;
    seen_v = 0;
    req = 4'b0001;
    tick();
    req = 4'b0000;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (ack !== 4'b0000) seen_v = n;
    end
    checks++; if (seen_v != 0 || busy !== 1'b1) begin failures++; $display("FAIL no_to_wait got=ack@%0d/busy%b exp=none/1", seen_v, busy); end
    m_done = 1'b1; m_dout = 8'h12; m_err = 1'b0;
    tick();
    m_done = 1'b0;
    checks++; if ({ack, rsp_dout} !== {4'b0001, 8'h12}) begin failures++; $display("FAIL no_to_ack got=%h exp=%h", {ack, rsp_dout}, {4'b0001, 8'h12}); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_read();
    test_error();
    test_pointer_skip();
    test_reset_mid_run();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_req_arbiter.md
# spi_req_arbiter

Round-robin arbiter and sequencer that shares one SPI master controller among NUM_REQ independent requesters. Holds the master in reset while idle, loads one granted request onto its wr/addr/din inputs, and releases it for exactly one transaction. Captures done/err/dout and returns them to the winner with an ack pulse. Sits between on-chip register clients and the SPI master.

## Interface
- NUM_REQ, 4: number of requesters (2..8)
- TIMEOUT, 255: max cycles in RUN before abort (used only with SPI_ARB_TIMEOUT_EN)
- clk  in  1  system clock, all logic on posedge
- rst  in  1  reset, asynchronous, active-low
- req  in  NUM_REQ  per-requester request level
- req_wr  in  NUM_REQ  per-requester op: 1 write, 0 read
- req_addr  in  8*NUM_REQ  per-requester address, slice i = [8i+7:8i]
- req_din  in  8*NUM_REQ  per-requester write data, same slicing
- gnt  out  NUM_REQ  one-hot, one-cycle grant pulse
- ack  out  NUM_REQ  one-hot, one-cycle completion pulse
- rsp_dout  out  8  read data of last completed transaction
- rsp_err  out  1  error status of last completed transaction
- busy  out  1  high from grant until ack, inclusive
- m_rst  out  1  master reset, active-high
- m_wr, m_addr[7:0], m_din[7:0]  out  master request fields
- m_done, m_err  in  1  master completion and error flags
- m_dout  in  8  master read data

## Operation
- States: IDLE, RUN, RESP.
- IDLE: m_rst=1. If any req bit is set, select the winner by round-robin: search starts at index ptr, wraps modulo NUM_REQ.
- On selection, latch the winner's wr/addr/din into m_wr/m_addr/m_din, pulse gnt[winner] for one cycle, set busy, and go to RUN.
- RUN: m_rst=0; m_* fields held constant. On m_done=1, capture rsp_dout<=m_dout, rsp_err<=m_err, and go to RESP.
- RESP: m_rst=1, ack[winner]=1 for one cycle, ptr<=(winner+1) mod NUM_REQ, busy cleared, return to IDLE.
- Request protocol: req is held until gnt is seen. Fields are sampled in the grant cycle only. A req dropped before grant is never served. A req still high after ack is arbitrated again, as a new transaction.
- rsp_dout/rsp_err hold their values until the next RESP.
- req changes during RUN have no effect on the active transaction.
- Address range checking is left to the master; m_err is passed through unchanged.

## Timing
- Reset values: gnt=0, ack=0, busy=0, rsp_dout=0, rsp_err=0, m_rst=1, m_wr=0, m_addr=0, m_din=0, ptr=0, state=IDLE.
- req seen at edge k: gnt, busy and the m_* fields are valid after edge k; m_rst falls after edge k.
- m_done seen at edge j: ack, rsp_* and m_rst=1 are valid after edge j; state is IDLE after edge j+1.
- Minimum gap between acks for back-to-back requests: master transaction time + 2 cycles.
- Reset asserted mid-RUN: all outputs take reset values immediately (asynchronous); no ack is issued for the aborted transaction.
- Fairness: with all req bits held high, grant order is 0,1,2,3,0,...

## Configuration
- SPI_ARB_TIMEOUT_EN defined:
  - An 8-bit-or-wider counter clears on entry to RUN and increments each RUN cycle.
  - When the count reaches TIMEOUT without m_done, go to RESP with rsp_err=1 and rsp_dout=0.
  - m_done and timeout in the same cycle: m_done wins.
- SPI_ARB_TIMEOUT_EN undefined: no counter; RUN waits indefinitely for m_done.

## Test plan
- Reset, then req=0001, wr=1, addr=0x05, din=0xA5 -> gnt=0001 one cycle; m_addr=0x05, m_din=0xA5, m_wr=1 stable through RUN; ack=0001 after m_done; rsp_err=0.
- req=1111 held for 4 transactions -> grants in order 0001, 0010, 0100, 1000; ptr wraps to 0.
- Read by req[2], addr=0x10, master returns m_dout=0x3C -> ack=0100, rsp_dout=0x3C held until next ack.
- req[1] write with addr=0x40 and master m_err=1 -> ack=0010, rsp_err=1, busy low after ack.
- rst low during RUN -> m_rst=1, busy=0, gnt=ack=0 immediately; after release, a fresh req[3] grants 1000 (search starts at ptr=0).
- SPI_ARB_TIMEOUT_EN defined, TIMEOUT=20, m_done never asserted -> ack after 20 RUN cycles with rsp_err=1, rsp_dout=0, m_rst=1.
